// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter:
// FSM state encoding, round-robin pointer encoding and register count.
package regfile_write_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 2 ** DEF_ADDR_WIDTH;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_e;

  typedef enum logic {
    PTR_R0 = 1'b0,
    PTR_R1 = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/decoder_5_32.sv
// 5-to-32 one-hot decoder with an enable; output is all zero when disabled.
module decoder_5_32 (
  input  logic        i_en,
  input  logic [4:0]  i_addr,
  output logic [31:0] o_sel
);

  always_comb begin
    o_sel = '0;
    if (i_en) o_sel[i_addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: clears every row after reset, then
// shares the port between the ALU (R0) and load (R1) write-back requesters.
import regfile_write_arbiter_pkg::*;

module regfile_write_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int NUM_REGS_L    = 2 ** ADDR_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Req0Valid,
  input  logic [ADDR_WIDTH-1:0] Req0Addr,
  input  logic [DATA_WIDTH-1:0] Req0Data,
  output logic                  Req0Ready,
  input  logic                  Req1Valid,
  input  logic [ADDR_WIDTH-1:0] Req1Addr,
  input  logic [DATA_WIDTH-1:0] Req1Data,
  output logic                  Req1Ready,
  output logic                  WrEn,
  output logic [ADDR_WIDTH-1:0] WrAddr,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic [NUM_REGS_L-1:0] WrSel,
  output logic                  Busy,
  output logic                  ClearDone
);

  // Handshake: a requester transfers in any cycle where its Valid and Ready
  // are both high; Ready is the combinational grant and is only ever raised
  // in RUN. Requesters hold Valid/Addr/Data stable until they see Ready.

  arb_state_e            r_state;
  rr_ptr_e               r_ptr;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_busy;
  logic                  r_clear_done;

  logic w_run;
  logic w_both;
  logic w_grant0;
  logic w_grant1;

  assign w_run    = (r_state == ST_RUN);
  assign w_both   = Req0Valid && Req1Valid;
  assign w_grant0 = w_run && Req0Valid && (!Req1Valid || (r_ptr == PTR_R0));
  assign w_grant1 = w_run && Req1Valid && (!Req0Valid || (r_ptr == PTR_R1));

  assign Req0Ready = w_grant0;
  assign Req1Ready = w_grant1;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      r_ptr        <= PTR_R0;
      r_cnt        <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_busy       <= CLEAR_ON_RESET;
      r_clear_done <= !CLEAR_ON_RESET;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_cnt;
          r_wr_data <= '0;
          r_cnt     <= r_cnt + 1'b1;
          if (&r_cnt) begin
            r_state      <= ST_RUN;
            r_busy       <= 1'b0;
            r_clear_done <= 1'b1;
          end
        end
        ST_RUN: begin
          // Register 0 is hardwired zero: accept the request, write nothing.
          if (w_grant0) begin
            r_wr_en <= (Req0Addr != '0);
            if (Req0Addr != '0) begin
              r_wr_addr <= Req0Addr;
              r_wr_data <= Req0Data;
            end
            if (w_both) r_ptr <= PTR_R1;
          end else if (w_grant1) begin
            r_wr_en <= (Req1Addr != '0);
            if (Req1Addr != '0) begin
              r_wr_addr <= Req1Addr;
              r_wr_data <= Req1Data;
            end
            if (w_both) r_ptr <= PTR_R0;
          end else begin
            r_wr_en <= 1'b0;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign WrEn      = r_wr_en;
  assign WrAddr    = r_wr_addr;
  assign WrData    = r_wr_data;
  assign Busy      = r_busy;
  assign ClearDone = r_clear_done;

  // Row select is decoded from registered outputs only, so it cannot glitch.
  generate
    if (ADDR_WIDTH == DEF_ADDR_WIDTH) begin : g_dec
      decoder_5_32 u_dec (
        .i_en   (r_wr_en),
        .i_addr (r_wr_addr),
        .o_sel  (WrSel)
      );
    end else begin : g_shift
      assign WrSel = r_wr_en ? ({{(NUM_REGS_L-1){1'b0}}, 1'b1} << r_wr_addr) : '0;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed clear/reset sequences, a vector
// table for arbitration cases, and randomized traffic against a model.
module tb_regfile_write_arbiter;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Req0Valid, Req1Valid;
  logic [4:0]  Req0Addr, Req1Addr;
  logic [31:0] Req0Data, Req1Data;
  logic        Req0Ready, Req1Ready;
  logic        WrEn;
  logic [4:0]  WrAddr;
  logic [31:0] WrData;
  logic [31:0] WrSel;
  logic        Busy, ClearDone;

  int n_assert = 0;
  int n_fail   = 0;

  // clock / reset
  always #5 Clk = ~Clk;

  regfile_write_arbiter dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Req0Valid (Req0Valid),
    .Req0Addr  (Req0Addr),
    .Req0Data  (Req0Data),
    .Req0Ready (Req0Ready),
    .Req1Valid (Req1Valid),
    .Req1Addr  (Req1Addr),
    .Req1Data  (Req1Data),
    .Req1Ready (Req1Ready),
    .WrEn      (WrEn),
    .WrAddr    (WrAddr),
    .WrData    (WrData),
    .WrSel     (WrSel),
    .Busy      (Busy),
    .ClearDone (ClearDone)
  );

  // reference model: clear progress, arbitration pointer, expected port
  bit          m_in_clear;
  int          m_idx;
  bit          m_ptr;
  bit          m_done;
  bit          m_wren;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [36:0] exp_q[$];
  logic        act_r0, act_r1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_clear = 1'b1;
    m_idx      = 0;
    m_ptr      = 1'b0;
    m_done     = 1'b0;
    m_wren     = 1'b0;
    m_waddr    = '0;
    m_wdata    = '0;
    exp_q.delete();
  endtask

  // driver: one clock cycle of stimulus, checked against the model
  task automatic step(input bit rst,
                      input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                      input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                      output bit g0, output bit g1);
    logic [36:0] w;
    logic [63:0] sel;
    Rst = rst;
    Req0Valid = v0; Req0Addr = a0; Req0Data = d0;
    Req1Valid = v1; Req1Addr = a1; Req1Data = d1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst && !m_in_clear) begin
      if (v0 && v1) begin
        if (m_ptr == 1'b0) g0 = 1'b1; else g1 = 1'b1;
        m_ptr = ~m_ptr;
      end else begin
        g0 = v0;
        g1 = v1;
      end
    end
    @(negedge Clk);
    act_r0 = Req0Ready;
    act_r1 = Req1Ready;
    if (!rst) begin
      chk("req0_ready", {63'd0, act_r0}, {63'd0, g0});
      chk("req1_ready", {63'd0, act_r1}, {63'd0, g1});
    end
    if (rst) begin
      model_reset();
    end else if (m_in_clear) begin
      m_wren  = 1'b1;
      m_waddr = m_idx[4:0];
      m_wdata = '0;
      m_idx++;
      if (m_idx == 32) begin
        m_in_clear = 1'b0;
        m_done     = 1'b1;
      end
    end else if ((g0 && a0 != 0) || (g1 && a1 != 0)) begin
      m_wren  = 1'b1;
      m_waddr = g0 ? a0 : a1;
      m_wdata = g0 ? d0 : d1;
    end else begin
      m_wren = 1'b0;
    end
    if (m_wren) exp_q.push_back({m_waddr, m_wdata});
    @(posedge Clk);
    #1;
    chk("wr_en", {63'd0, WrEn}, {63'd0, m_wren});
    if (m_wren) begin
      w = exp_q.pop_front();
      chk("wr_stream", {27'd0, WrAddr, WrData}, {27'd0, w});
    end else begin
      chk("wr_addr_hold", {59'd0, WrAddr}, {59'd0, m_waddr});
      chk("wr_data_hold", {32'd0, WrData}, {32'd0, m_wdata});
    end
    sel = m_wren ? (64'd1 << m_waddr) : 64'd0;
    chk("wr_sel", {32'd0, WrSel}, sel);
    chk("busy", {63'd0, Busy}, {63'd0, m_in_clear});
    chk("clear_done", {63'd0, ClearDone}, {63'd0, m_done});
  endtask

  typedef struct {
    bit          v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    bit          v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    bit          e_r0;
    bit          e_r1;
    bit          e_wren;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_sel;
  } vec_t;

  vec_t vecs[12];

  initial begin
    bit g0, g1;
    bit p0, p1;
    logic [4:0]  ra0, ra1;
    logic [31:0] rd0, rd1;

    model_reset();
    Rst = 1'b1;
    Req0Valid = 1'b0; Req0Addr = '0; Req0Data = '0;
    Req1Valid = 1'b0; Req1Addr = '0; Req1Data = '0;

    // single requester, contention R0/R1 alternation, register 0, idle hold
    vecs[0]  = '{1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'h0, 1, 0, 1, 5'd5, 32'hDEAD_BEEF, 32'h0000_0020};
    vecs[1]  = '{1, 5'd3, 32'h3333_0003, 1, 5'd7, 32'h7777_0007, 1, 0, 1, 5'd3, 32'h3333_0003, 32'h0000_0008};
    vecs[2]  = '{1, 5'd3, 32'h3333_0003, 1, 5'd7, 32'h7777_0007, 0, 1, 1, 5'd7, 32'h7777_0007, 32'h0000_0080};
    vecs[3]  = '{1, 5'd3, 32'h3333_0003, 1, 5'd7, 32'h7777_0007, 1, 0, 1, 5'd3, 32'h3333_0003, 32'h0000_0008};
    vecs[4]  = '{1, 5'd3, 32'h3333_0003, 1, 5'd7, 32'h7777_0007, 0, 1, 1, 5'd7, 32'h7777_0007, 32'h0000_0080};
    vecs[5]  = '{0, 5'd0, 32'h0, 1, 5'd0, 32'h0000_1234, 0, 1, 0, 5'd7, 32'h7777_0007, 32'h0};
    vecs[6]  = '{0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 5'd7, 32'h7777_0007, 32'h0};
    vecs[7]  = '{0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 5'd7, 32'h7777_0007, 32'h0};
    vecs[8]  = '{0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 5'd7, 32'h7777_0007, 32'h0};
    vecs[9]  = '{0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 5'd7, 32'h7777_0007, 32'h0};
    vecs[10] = '{0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 5'd7, 32'h7777_0007, 32'h0};
    vecs[11] = '{0, 5'd0, 32'h0, 1, 5'd31, 32'hFFFF_0001, 0, 1, 1, 5'd31, 32'hFFFF_0001, 32'h8000_0000};

    // reset for two cycles
    for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0, 0, 0, g0, g1);
    chk("rst_wr_en", {63'd0, WrEn}, 64'd0);
    chk("rst_busy", {63'd0, Busy}, 64'd1);
    chk("rst_clear_done", {63'd0, ClearDone}, 64'd0);

    // full clear sequence
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, g0, g1);
      chk("clr_ready", {62'd0, act_r0, act_r1}, 64'd0);
      chk("clr_addr", {59'd0, WrAddr}, 64'(i));
      chk("clr_sel", {32'd0, WrSel}, 64'd1 << i);
    end
    chk("clr_end_busy", {63'd0, Busy}, 64'd0);
    chk("clr_end_done", {63'd0, ClearDone}, 64'd1);

    // vector table
    for (int i = 0; i < 12; i++) begin
      step(0, vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1, g0, g1);
      chk($sformatf("vec%0d_ready", i), {62'd0, act_r0, act_r1}, {62'd0, vecs[i].e_r0, vecs[i].e_r1});
      chk($sformatf("vec%0d_wr_en", i), {63'd0, WrEn}, {63'd0, vecs[i].e_wren});
      chk($sformatf("vec%0d_addr", i), {59'd0, WrAddr}, {59'd0, vecs[i].e_addr});
      chk($sformatf("vec%0d_data", i), {32'd0, WrData}, {32'd0, vecs[i].e_data});
      chk($sformatf("vec%0d_sel", i), {32'd0, WrSel}, {32'd0, vecs[i].e_sel});
    end

    // reset in the middle of a clear, then a complete restarted clear
    step(1, 0, 0, 0, 0, 0, 0, g0, g1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 0, g0, g1);
    step(1, 0, 0, 0, 0, 0, 0, g0, g1);
    chk("midclr_wr_en", {63'd0, WrEn}, 64'd0);
    chk("midclr_busy", {63'd0, Busy}, 64'd1);
    chk("midclr_done", {63'd0, ClearDone}, 64'd0);
    for (int i = 0; i < 32; i++) begin
      step(0, 1, 5'd9, 32'hAAAA_5555, 0, 0, 0, g0, g1);
      chk("reclr_addr", {59'd0, WrAddr}, 64'(i));
      chk("reclr_busy", {63'd0, Busy}, (i < 31) ? 64'd1 : 64'd0);
    end
    // R0 has been waiting through the clear; it is accepted first in RUN
    step(0, 1, 5'd9, 32'hAAAA_5555, 0, 0, 0, g0, g1);
    chk("post_clr_grant", {63'd0, act_r0}, 64'd1);

    // randomized traffic; requesters hold their request until granted
    p0 = 0; p1 = 0;
    ra0 = '0; ra1 = '0; rd0 = '0; rd1 = '0;
    for (int i = 0; i < 600; i++) begin
      bit rst;
      if (!p0 && $urandom_range(0, 9) < 6) begin
        p0  = 1;
        ra0 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        rd0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 9) < 6) begin
        p1  = 1;
        ra1 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        rd1 = $urandom;
      end
      rst = ($urandom_range(0, 249) == 0);
      step(rst, p0, ra0, rd0, p1, ra1, rd1, g0, g1);
      if (g0) p0 = 0;
      if (g1) p1 = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
